// File: rtl/acsp_pkg.sv
// Shared types and default widths for the acquisition/trigger core.
package acsp_pkg;

   localparam int unsigned ACSP_DATA_W = 8;
   localparam int unsigned ACSP_DIV_W  = 24;

   // Acquisition phases: waiting for arm, hunting for trigger, streaming.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } state_t;

endpackage

// File: rtl/acsp_clk_div.sv
// Sample-rate divider: free-running counter that produces a tick when the
// count reaches the programmed divider.
//   system_clock  clock, rising edge
//   reset         asynchronous, active-high
//   clear         restart the count from 0 (takes priority)
//   enable        counting allowed; count held at 0 otherwise
//   divider       sample period minus one
//   tick_c        combinational tick for the current cycle
module acsp_clk_div
   import acsp_pkg::*;
#(
   parameter int unsigned DIV_W = ACSP_DIV_W
) (
   input  logic             system_clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [DIV_W-1:0] divider,
   output logic             tick_c
);

   logic [DIV_W-1:0] cnt;

   // >= rather than == so a divider lowered below the count ticks at once.
   assign tick_c = enable && (cnt >= divider);

   // Count register: cleared on arm, when idle, and on every tick.
   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear || !enable || tick_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/acsp_top.sv
// Logic-analyzer acquisition/trigger core. Samples the probe bus at the
// divided rate, waits for an armed edge/level trigger, then streams every
// sample tick to the capture FIFO with a one-clock valid strobe.
//   system_clock       clock, rising edge
//   reset              asynchronous, active-high
//   dataToSample       probe data (already synchronous)
//   fallPattern        falling-edge / must-be-0 bits
//   risePattern        rising-edge / must-be-1 bits
//   divider            sample period minus one
//   edge_capture       1 = edge trigger, 0 = level trigger
//   arm                rising edge (re)arms the trigger
//   run                high while capturing
//   dataSamplerToFIFO  captured sample
//   dataValidToFIFO    one-clock strobe qualifying dataSamplerToFIFO
module acsp_top
   import acsp_pkg::*;
#(
   parameter int unsigned DATA_W = ACSP_DATA_W,
   parameter int unsigned DIV_W  = ACSP_DIV_W
) (
   input  logic              system_clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] dataToSample,
   input  logic [DATA_W-1:0] fallPattern,
   input  logic [DATA_W-1:0] risePattern,
   input  logic [DIV_W-1:0]  divider,
   input  logic              edge_capture,
   input  logic              arm,
   output logic              run,
   output logic [DATA_W-1:0] dataSamplerToFIFO,
   output logic              dataValidToFIFO
);

   state_t            state_q, state_d;
   logic              arm_q;
   logic              arm_pulse_c;
   logic              div_en_c;
   logic              tick_c;
   logic              trig_c;
   logic              edge_hit_c;
   logic              level_hit_c;
   logic              primed_q, primed_d;
   logic [DATA_W-1:0] ref_q, ref_d;
   logic              run_d;
   logic [DATA_W-1:0] data_d;
   logic              valid_d;

   assign arm_pulse_c = arm && !arm_q;
   assign div_en_c    = (state_q != IDLE);

   acsp_clk_div #(
      .DIV_W (DIV_W)
   ) u_clk_div (
      .system_clock (system_clock),
      .reset        (reset),
      .clear        (arm_pulse_c),
      .enable       (div_en_c),
      .divider      (divider),
      .tick_c       (tick_c)
   );

   // Edge: any armed bit moved in its armed direction since the last tick.
   assign edge_hit_c  = (|((ref_q & ~dataToSample) & fallPattern)) ||
                        (|((~ref_q & dataToSample) & risePattern));
   // Level: all armed bits at their required value, and at least one armed.
   assign level_hit_c = ((dataToSample & risePattern) == risePattern) &&
                        ((~dataToSample & fallPattern) == fallPattern) &&
                        ((risePattern | fallPattern) != '0);
   assign trig_c      = edge_capture ? edge_hit_c : level_hit_c;

   // Next-state / next-output logic; arm pulse overrides everything.
   always_comb begin
      state_d  = state_q;
      primed_d = primed_q;
      ref_d    = ref_q;
      run_d    = run;
      data_d   = dataSamplerToFIFO;
      valid_d  = 1'b0;
      if (arm_pulse_c) begin
         state_d  = ARMED;
         primed_d = 1'b0;
         run_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
            end
            ARMED: begin
               if (tick_c) begin
                  ref_d = dataToSample;
                  // First tick after arming only establishes the reference.
                  if (!primed_q) begin
                     primed_d = 1'b1;
                  end else if (trig_c) begin
                     state_d = RUN;
                     run_d   = 1'b1;
                     data_d  = dataToSample;
                     valid_d = 1'b1;
                  end
               end
            end
            RUN: begin
               if (tick_c) begin
                  ref_d   = dataToSample;
                  data_d  = dataToSample;
                  valid_d = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               run_d   = 1'b0;
            end
         endcase
      end
   end

   // State and registered outputs.
   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         state_q           <= IDLE;
         arm_q             <= 1'b0;
         primed_q          <= 1'b0;
         ref_q             <= '0;
         run               <= 1'b0;
         dataSamplerToFIFO <= '0;
         dataValidToFIFO   <= 1'b0;
      end else begin
         state_q           <= state_d;
         arm_q             <= arm;
         primed_q          <= primed_d;
         ref_q             <= ref_d;
         run               <= run_d;
         dataSamplerToFIFO <= data_d;
         dataValidToFIFO   <= valid_d;
      end
   end

endmodule

// File: tb/tb_acsp_top.sv
// Self-checking bench for acsp_top: a cycle model of the acquisition rules
// compared every clock, plus directed scenarios with literal expectations.
module tb_acsp_top;

   localparam int unsigned DW = 8;
   localparam int unsigned VW = 24;

   logic          system_clock = 1'b0;
   logic          reset        = 1'b1;
   logic [DW-1:0] dataToSample = '0;
   logic [DW-1:0] fallPattern  = '0;
   logic [DW-1:0] risePattern  = '0;
   logic [VW-1:0] divider      = '0;
   logic          edge_capture = 1'b1;
   logic          arm          = 1'b0;
   logic          run;
   logic [DW-1:0] dataSamplerToFIFO;
   logic          dataValidToFIFO;

   int checks = 0;
   int errors = 0;

   // Strobe log filled by the compare process, read by directed checks.
   int            n_strobes  = 0;
   logic [DW-1:0] first_data = '0;
   logic [DW-1:0] last_data  = '0;
   int            last_cyc   = 0;
   int            prev_cyc   = 0;
   int            cyc        = 0;

   // Model state.
   int            m_mode     = 0;   // 0 waiting for arm, 1 hunting, 2 streaming
   int            m_since    = 0;   // clocks since the last sample tick / arm
   bit            m_have_ref = 1'b0;
   logic [DW-1:0] m_prev     = '0;
   bit            m_arm_prev = 1'b0;
   bit            exp_run    = 1'b0;
   bit            exp_valid  = 1'b0;
   logic [DW-1:0] exp_data   = '0;

   acsp_top #(
      .DATA_W (DW),
      .DIV_W  (VW)
   ) dut (
      .system_clock      (system_clock),
      .reset             (reset),
      .dataToSample      (dataToSample),
      .fallPattern       (fallPattern),
      .risePattern       (risePattern),
      .divider           (divider),
      .edge_capture      (edge_capture),
      .arm               (arm),
      .run               (run),
      .dataSamplerToFIFO (dataSamplerToFIFO),
      .dataValidToFIFO   (dataValidToFIFO)
   );

   always #5 system_clock = ~system_clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, req);
      end
   endtask

   // Trigger rule evaluated bit by bit.
   function automatic bit fires(input bit edge_m, input logic [DW-1:0] prev,
                                input logic [DW-1:0] cur, input logic [DW-1:0] rise,
                                input logic [DW-1:0] fall);
      bit any_armed = 1'b0;
      bit all_ok    = 1'b1;
      bit moved     = 1'b0;
      for (int i = 0; i < int'(DW); i++) begin
         if (rise[i]) begin
            any_armed = 1'b1;
            if (!cur[i]) all_ok = 1'b0;
            if (!prev[i] && cur[i]) moved = 1'b1;
         end
         if (fall[i]) begin
            any_armed = 1'b1;
            if (cur[i]) all_ok = 1'b0;
            if (prev[i] && !cur[i]) moved = 1'b1;
         end
      end
      return edge_m ? moved : (any_armed && all_ok);
   endfunction

   // Model advance at each rising edge, then compare just after it.
   always @(posedge system_clock) begin
      bit pulse;
      bit smp;
      exp_valid = 1'b0;
      if (reset) begin
         m_mode = 0; m_since = 0; m_have_ref = 1'b0; m_prev = '0;
         m_arm_prev = 1'b0; exp_run = 1'b0; exp_data = '0;
      end else begin
         pulse      = arm && !m_arm_prev;
         m_arm_prev = arm;
         if (pulse) begin
            m_mode = 1; m_since = 0; m_have_ref = 1'b0; exp_run = 1'b0;
         end else if (m_mode != 0) begin
            smp = (m_since >= int'(divider));
            m_since = smp ? 0 : m_since + 1;
            if (smp) begin
               if (m_mode == 2) begin
                  exp_data = dataToSample; exp_valid = 1'b1;
               end else if (!m_have_ref) begin
                  m_have_ref = 1'b1;
               end else if (fires(edge_capture, m_prev, dataToSample, risePattern, fallPattern)) begin
                  m_mode = 2; exp_run = 1'b1; exp_data = dataToSample; exp_valid = 1'b1;
               end
               m_prev = dataToSample;
            end
         end
      end
      #1;
      check("run", 32'(run), 32'(exp_run));
      check("valid", 32'(dataValidToFIFO), 32'(exp_valid));
      check("data", 32'(dataSamplerToFIFO), 32'(exp_data));
      if (dataValidToFIFO) begin
         n_strobes++;
         if (n_strobes == 1) first_data = dataSamplerToFIFO;
         last_data = dataSamplerToFIFO;
         prev_cyc  = last_cyc;
         last_cyc  = cyc;
      end
      cyc++;
   end

   // Called at a falling edge; arm is high across exactly one rising edge.
   task automatic do_arm();
      n_strobes = 0;
      arm = 1'b1;
      @(negedge system_clock);
      arm = 1'b0;
   endtask

   task automatic drive_ramp(input int start, input int count);
      for (int i = 0; i < count; i++) begin
         dataToSample = DW'(start + i);
         @(negedge system_clock);
      end
   endtask

   initial begin
      repeat (3) @(negedge system_clock);
      check("reset_run", 32'(run), 32'd0);
      check("reset_valid", 32'(dataValidToFIFO), 32'd0);
      check("reset_data", 32'(dataSamplerToFIFO), 32'd0);
      reset = 1'b0;
      fallPattern = 8'h01;
      drive_ramp(0, 6);
      check("idle_no_strobe", 32'(n_strobes), 32'd0);

      // Edge trigger on bit0 falling.
      edge_capture = 1'b1; fallPattern = 8'h01; risePattern = 8'h00; divider = '0;
      do_arm();
      drive_ramp(0, 10);
      check("fall_first", 32'(first_data), 32'h02);
      check("fall_count", 32'(n_strobes), 32'd8);
      check("fall_run", 32'(run), 32'd1);

      // Edge trigger on bit7 rising.
      fallPattern = 8'h00; risePattern = 8'h80;
      do_arm();
      drive_ramp(0, 256);
      check("rise_first", 32'(first_data), 32'h80);
      check("rise_count", 32'(n_strobes), 32'd128);

      // Level trigger: bits 0,2 high and bit1 low; first sample only primes.
      edge_capture = 1'b0; risePattern = 8'h05; fallPattern = 8'h02;
      do_arm();
      dataToSample = 8'h05; @(negedge system_clock);
      dataToSample = 8'h04; @(negedge system_clock);
      dataToSample = 8'h04; @(negedge system_clock);
      check("level_hold", 32'(n_strobes), 32'd0);
      check("level_hold_run", 32'(run), 32'd0);
      dataToSample = 8'h05; @(negedge system_clock);
      dataToSample = 8'h07; @(negedge system_clock);
      check("level_first", 32'(first_data), 32'h05);
      check("level_count", 32'(n_strobes), 32'd2);
      check("level_last", 32'(last_data), 32'h07);

      // Divider 3 while streaming: one strobe every 4 clocks.
      n_strobes = 0; divider = 24'd3;
      drive_ramp(8'h10, 16);
      check("div_count", 32'(n_strobes), 32'd4);
      check("div_last", 32'(last_data), 32'h1F);
      check("div_spacing", 32'(last_cyc - prev_cyc), 32'd4);

      // Lowering the divider below the running count ticks on the next clock.
      n_strobes = 0;
      drive_ramp(8'h20, 2);
      divider = 24'd1; dataToSample = 8'hAA; @(negedge system_clock);
      check("div_lower_count", 32'(n_strobes), 32'd1);
      check("div_lower_data", 32'(last_data), 32'hAA);

      // Re-arm during RUN on a tick edge, with no armed pattern bits.
      divider = '0; edge_capture = 1'b1; fallPattern = 8'h00; risePattern = 8'h00;
      do_arm();
      check("rearm_run", 32'(run), 32'd0);
      check("rearm_no_strobe", 32'(n_strobes), 32'd0);
      drive_ramp(0, 300);
      check("nopat_edge", 32'(n_strobes), 32'd0);
      edge_capture = 1'b0;
      drive_ramp(0, 50);
      check("nopat_level", 32'(n_strobes), 32'd0);
      check("nopat_run", 32'(run), 32'd0);

      // Reset in the middle of a strobe.
      edge_capture = 1'b1; fallPattern = 8'h01;
      do_arm();
      drive_ramp(0, 6);
      check("pre_reset_valid", 32'(dataValidToFIFO), 32'd1);
      reset = 1'b1;
      #1;
      check("midrst_run", 32'(run), 32'd0);
      check("midrst_valid", 32'(dataValidToFIFO), 32'd0);
      check("midrst_data", 32'(dataSamplerToFIFO), 32'd0);
      @(negedge system_clock);
      reset = 1'b0; n_strobes = 0;
      drive_ramp(0, 20);
      check("post_reset_idle", 32'(n_strobes), 32'd0);
      check("post_reset_run", 32'(run), 32'd0);

      // Recovery after reset.
      do_arm();
      drive_ramp(0, 4);
      check("recover_first", 32'(first_data), 32'h02);
      check("recover_count", 32'(n_strobes), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
